// File: rtl/fmt_pkg.sv
// Shared constants and state encoding for the product formatter.
// Build option: FMT_ZERO_BLANK_EN (leading-zero blanking), consumed by product_formatter.
package fmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_SP = 8'h20;

    localparam int         DEF_DATA_W    = 33;
    localparam int         DEF_NDIGITS   = 9;
    localparam logic [4:0] DEF_BASE_ADDR = 5'd16;

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex character.
module hex_to_ascii
    import fmt_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + {4'h0, nibble};
        end else begin
            ascii = ASCII_A + {4'h0, nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/product_formatter.sv
// Captures a product on the rising edge of product_set and streams it as ASCII hex to the LCD driver.
// Build option: define FMT_ZERO_BLANK_EN to print leading zero digits as spaces.
module product_formatter
    import fmt_pkg::*;
#(
    parameter int         DATA_W    = DEF_DATA_W,
    parameter int         NDIGITS   = DEF_NDIGITS,
    parameter logic [4:0] BASE_ADDR = DEF_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] product,
    input  logic              product_set,
    output logic [7:0]        char_data,
    output logic [4:0]        char_addr,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int BUF_W = 4 * NDIGITS;
    localparam int CNT_W = $clog2(NDIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NDIGITS - 1);

    state_t           st_q, st_d;
    logic             set_q, set_d;
    logic [BUF_W-1:0] buffer_q, buffer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       char_data_q, char_data_d;
    logic [4:0]       char_addr_q, char_addr_d;
    logic             char_valid_q, char_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
`ifdef FMT_ZERO_BLANK_EN
    logic             lead_q, lead_d, lead_in;
`endif

    logic             rise;
    logic [BUF_W-1:0] cap_buf, shift_buf;
    logic [3:0]       nib;
    logic [7:0]       nib_ascii;
    logic [CNT_W-1:0] idx_next;
    logic             blank;

    // The digit being loaded next: top nibble of the fresh capture, or of the shifted buffer.
    always_comb begin
        cap_buf   = BUF_W'(product);
        shift_buf = buffer_q << 4;
        nib       = (st_q == ST_IDLE) ? cap_buf[BUF_W-1 -: 4] : shift_buf[BUF_W-1 -: 4];
        idx_next  = (st_q == ST_IDLE) ? '0 : cnt_q + CNT_W'(1);
    end

    hex_to_ascii u_hex (
        .nibble (nib),
        .ascii  (nib_ascii)
    );

    always_comb begin
`ifdef FMT_ZERO_BLANK_EN
        lead_in = (st_q == ST_IDLE) ? 1'b1 : lead_q;
        blank   = lead_in && (nib == 4'h0) && (idx_next != LAST_IDX);
`else
        blank   = 1'b0;
`endif
    end

    always_comb begin
        set_d        = product_set;
        rise         = product_set & ~set_q;
        st_d         = st_q;
        buffer_d     = buffer_q;
        cnt_d        = cnt_q;
        char_data_d  = char_data_q;
        char_addr_d  = char_addr_q;
        char_valid_d = char_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        overrun_d    = overrun_q | (rise & (st_q != ST_IDLE));
`ifdef FMT_ZERO_BLANK_EN
        lead_d       = lead_q;
`endif
        case (st_q)
            ST_IDLE: begin
                if (rise) begin
                    buffer_d     = cap_buf;
                    cnt_d        = '0;
                    char_data_d  = blank ? ASCII_SP : nib_ascii;
                    char_addr_d  = BASE_ADDR;
                    char_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    st_d         = ST_EMIT;
`ifdef FMT_ZERO_BLANK_EN
                    lead_d       = blank;
`endif
                end
            end
            ST_EMIT: begin
                if (char_valid_q && char_ready) begin
                    buffer_d    = shift_buf;
                    cnt_d       = idx_next;
                    char_data_d = blank ? ASCII_SP : nib_ascii;
                    char_addr_d = BASE_ADDR + 5'(idx_next);
`ifdef FMT_ZERO_BLANK_EN
                    lead_d      = blank;
`endif
                    if (cnt_q == LAST_IDX) begin
                        char_valid_d = 1'b0;
                        char_data_d  = ASCII_SP;
                        char_addr_d  = BASE_ADDR;
                        done_d       = 1'b1;
                        st_d         = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
                st_d   = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q         <= ST_IDLE;
            set_q        <= 1'b0;
            buffer_q     <= '0;
            cnt_q        <= '0;
            char_data_q  <= ASCII_SP;
            char_addr_q  <= BASE_ADDR;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef FMT_ZERO_BLANK_EN
            lead_q       <= 1'b0;
`endif
        end else begin
            st_q         <= st_d;
            set_q        <= set_d;
            buffer_q     <= buffer_d;
            cnt_q        <= cnt_d;
            char_data_q  <= char_data_d;
            char_addr_q  <= char_addr_d;
            char_valid_q <= char_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overrun_q    <= overrun_d;
`ifdef FMT_ZERO_BLANK_EN
            lead_q       <= lead_d;
`endif
        end
    end

    assign char_data  = char_data_q;
    assign char_addr  = char_addr_q;
    assign char_valid = char_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;

endmodule
